// File: rtl/rgb_stream_packer_if.sv
// Pixel-in / AXI4-Stream-out bundle for rgb_stream_packer.
// slave = packer side, master = pixel source plus stream sink.
interface rgb_stream_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport slave (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );

    modport master (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 px -> 3 words).
// Optional PACKER_LINE_CNT_EN adds the line_count output and counter.
module rgb_stream_packer #(
    parameter int LINE_CNT_W = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
`ifdef PACKER_LINE_CNT_EN
    output logic [LINE_CNT_W-1:0] line_count,
`endif
    rgb_stream_packer_if.slave    s
);
    typedef enum logic {PACK, FLUSH} state_e;

    if (LINE_CNT_W < 1) begin : g_bad_width
        $error("LINE_CNT_W must be at least 1");
    end

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [23:0] res_q, res_d;
    logic [3:0]  fkeep_q, fkeep_d;
    logic        pend_q, pend_d;
    logic [31:0] tdata_q, tdata_d;
    logic [3:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;

    logic [23:0] px;
    logic [1:0]  ph;
    logic        out_free, ready, accept, wuser;
    logic        load, llast, luser;
    logic [31:0] ldata;
    logic [3:0]  lkeep;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        res_d    = res_q;
        fkeep_d  = fkeep_q;
        pend_d   = pend_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        load     = 1'b0;
        ldata    = '0;
        lkeep    = '0;
        llast    = 1'b0;
        luser    = 1'b0;

        px       = {s.r, s.g, s.b};
        out_free = !tvalid_q || s.out_stream_tready;
        ready    = (state_q == PACK) && (phase_q == 2'd0 || out_free);
        accept   = s.valid && ready;
        // sof realigns to a fresh group, dropping any residue
        ph       = s.sof ? 2'd0 : phase_q;
        wuser    = s.sof || pend_q;

        if (tvalid_q && s.out_stream_tready) tvalid_d = 1'b0;

        if (state_q == FLUSH) begin
            if (out_free) begin
                load    = 1'b1;
                ldata   = {8'h00, res_q};
                lkeep   = fkeep_q;
                llast   = 1'b1;
                luser   = pend_q;
                res_d   = '0;
                state_d = PACK;
            end
        end else if (accept) begin
            case (ph)
                2'd0: begin
                    phase_d = 2'd0;
                    if (s.eol) begin
                        if (out_free) begin
                            load  = 1'b1;
                            ldata = {8'h00, px};
                            lkeep = 4'b0111;
                            llast = 1'b1;
                            luser = wuser;
                        end else begin
                            // output busy: park the lone pixel and emit it via FLUSH
                            res_d   = px;
                            fkeep_d = 4'b0111;
                            pend_d  = wuser;
                            state_d = FLUSH;
                        end
                    end else begin
                        res_d   = px;
                        pend_d  = wuser;
                        phase_d = 2'd1;
                    end
                end
                2'd1: begin
                    load  = 1'b1;
                    ldata = {px[7:0], res_q};
                    lkeep = 4'hF;
                    luser = pend_q;
                    res_d = {8'h00, px[23:8]};
                    if (s.eol) begin
                        fkeep_d = 4'b0011;
                        state_d = FLUSH;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = 2'd2;
                    end
                end
                2'd2: begin
                    load  = 1'b1;
                    ldata = {px[15:0], res_q[15:0]};
                    lkeep = 4'hF;
                    luser = pend_q;
                    res_d = {16'h0000, px[23:16]};
                    if (s.eol) begin
                        fkeep_d = 4'b0001;
                        state_d = FLUSH;
                        phase_d = 2'd0;
                    end else begin
                        phase_d = 2'd3;
                    end
                end
                default: begin
                    load    = 1'b1;
                    ldata   = {px, res_q[7:0]};
                    lkeep   = 4'hF;
                    llast   = s.eol;
                    luser   = pend_q;
                    res_d   = '0;
                    phase_d = 2'd0;
                end
            endcase
        end

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = ldata;
            tkeep_d  = lkeep;
            tlast_d  = llast;
            tuser_d  = luser;
            pend_d   = 1'b0;
        end
    end

`ifdef PACKER_LINE_CNT_EN
    logic [LINE_CNT_W-1:0] lc_q, lc_d;

    always_comb begin
        lc_d = lc_q;
        if (tvalid_q && s.out_stream_tready) begin
            if (tuser_q)      lc_d = tlast_q ? LINE_CNT_W'(1) : '0;
            else if (tlast_q) lc_d = lc_q + LINE_CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lc_q <= '0;
        else          lc_q <= lc_d;
    end

    assign line_count = lc_q;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= PACK;
            phase_q  <= 2'd0;
            res_q    <= '0;
            fkeep_q  <= '0;
            pend_q   <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            res_q    <= res_d;
            fkeep_q  <= fkeep_d;
            pend_q   <= pend_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s.in_stream_ready   = ready;
    assign s.out_stream_tdata  = tdata_q;
    assign s.out_stream_tkeep  = tkeep_q;
    assign s.out_stream_tlast  = tlast_q;
    assign s.out_stream_tuser  = tuser_q;
    assign s.out_stream_tvalid = tvalid_q;
endmodule

// File: tb/tb_rgb_stream_packer.sv
// Scoreboard bench for rgb_stream_packer: directed pixel streams, expected
// words queued at stimulus time and checked by an independent output monitor.
module tb_rgb_stream_packer;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    rgb_stream_packer_if bus();
`ifdef PACKER_LINE_CNT_EN
    logic [15:0] line_count;
`endif

    rgb_stream_packer #(.LINE_CNT_W(16)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
`ifdef PACKER_LINE_CNT_EN
        .line_count (line_count),
`endif
        .s          (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } word_t;

    localparam logic [23:0] PA = 24'h112233;
    localparam logic [23:0] PB = 24'h445566;
    localparam logic [23:0] PC = 24'h778899;
    localparam logic [23:0] PD = 24'hAABBCC;

    word_t exp_q[$];
    word_t mon_act, mon_exp;
    int    errors = 0;
    int    checks = 0;

    always @(negedge aclk) begin
        if (aresetn && bus.out_stream_tvalid && bus.out_stream_tready) begin
            mon_act = {bus.out_stream_tdata, bus.out_stream_tkeep,
                       bus.out_stream_tlast, bus.out_stream_tuser};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got %h (data/keep/last/user), none expected", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL word: got %h want %h (data/keep/last/user)", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        word_t w;
        w = {d, k, l, u};
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [23:0] p, input logic s, input logic e);
        int n;
        bus.r = p[23:16]; bus.g = p[15:8]; bus.b = p[7:0];
        bus.sof = s; bus.eol = e; bus.valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_stream_ready && n < 100) begin
            @(negedge aclk); #1;
            n++;
        end
        if (n >= 100) begin
            errors++; checks++;
            $display("FAIL send_timeout: pixel %h not accepted in 100 cycles", p);
        end
        @(posedge aclk); #1;
        bus.valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, bus.out_stream_tvalid}, 32'd0);
        chk({tag, "_tdata"},  bus.out_stream_tdata, 32'd0);
        chk({tag, "_tkeep_last_user"},
            {27'd0, bus.out_stream_tkeep, bus.out_stream_tlast, bus.out_stream_tuser}, 32'd0);
    endtask

    initial begin
        bus.r = '0; bus.g = '0; bus.b = '0;
        bus.valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
        bus.out_stream_tready = 1'b1;

        #12;
        chk_reset_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("ready_after_reset", {31'd0, bus.in_stream_ready}, 32'd1);

        // 1: full group of four, eol on D
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b1, 1'b0);
        send(PA, 1'b0, 1'b0); send(PB, 1'b0, 1'b0);
        send(PC, 1'b0, 1'b0); send(PD, 1'b0, 1'b1);
        drain("drain_s1");

        // 2: sof on A, sink stalls for 5 cycles after word0
        push(32'h66112233, 4'hF, 1'b0, 1'b1);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b1, 1'b0);
        send(PA, 1'b1, 1'b0);
        bus.out_stream_tready = 1'b0;
        send(PB, 1'b0, 1'b0);
        fork
            begin
                send(PC, 1'b0, 1'b0);
                send(PD, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge aclk);
                    chk("hold_tdata", bus.out_stream_tdata, 32'h66112233);
                    chk("hold_valid_user_ready",
                        {29'd0, bus.out_stream_tvalid, bus.out_stream_tuser, bus.in_stream_ready},
                        32'b110);
                end
                @(posedge aclk); #1;
                bus.out_stream_tready = 1'b1;
            end
        join
        drain("drain_s2");

        // 3: eol at phase 1 -> flush two residue bytes
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'h00004455, 4'b0011, 1'b1, 1'b0);
        send(PA, 1'b0, 1'b0);
        send(PB, 1'b0, 1'b1);
        chk("ready_low_in_flush", {31'd0, bus.in_stream_ready}, 32'd0);
        drain("drain_s3");

        // eol at phase 2 -> one residue byte
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'h00000077, 4'b0001, 1'b1, 1'b0);
        send(PA, 1'b0, 1'b0); send(PB, 1'b0, 1'b0); send(PC, 1'b0, 1'b1);
        drain("drain_ph2_eol");

        // sof and eol on one pixel at phase 0
        push(32'h00123456, 4'b0111, 1'b1, 1'b1);
        send(24'h123456, 1'b1, 1'b1);
        drain("drain_sof_eol");

        // 4: sof on C mid-group drops B's residue
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'hCC778899, 4'hF, 1'b0, 1'b1);
        push(32'h0203AABB, 4'hF, 1'b0, 1'b0);
        push(32'h04050601, 4'hF, 1'b1, 1'b0);
        send(PA, 1'b0, 1'b0); send(PB, 1'b0, 1'b0);
        send(PC, 1'b1, 1'b0); send(PD, 1'b0, 1'b0);
        send(24'h010203, 1'b0, 1'b0); send(24'h040506, 1'b0, 1'b1);
        drain("drain_s4");

        // 5: reset with word0 pending and B residue held
        send(PA, 1'b0, 1'b0); send(PB, 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge aclk);
        aresetn = 1'b1;
        push(32'h66112233, 4'hF, 1'b0, 1'b0);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b1, 1'b0);
        send(PA, 1'b0, 1'b0); send(PB, 1'b0, 1'b0);
        send(PC, 1'b0, 1'b0); send(PD, 1'b0, 1'b1);
        drain("drain_s5");

`ifdef PACKER_LINE_CNT_EN
        // 6: three lines counted, next frame's first word zeroes the count
        for (int ln = 0; ln < 3; ln++) begin
            push(32'h66112233, 4'hF, 1'b0, ln == 0);
            push(32'h88994455, 4'hF, 1'b0, 1'b0);
            push(32'hAABBCC77, 4'hF, 1'b1, 1'b0);
            send(PA, ln == 0, 1'b0); send(PB, 1'b0, 1'b0);
            send(PC, 1'b0, 1'b0); send(PD, 1'b0, 1'b1);
            drain("drain_s6");
            chk("line_count", {16'd0, line_count}, 32'(ln + 1));
        end
        push(32'h66112233, 4'hF, 1'b0, 1'b1);
        send(PA, 1'b1, 1'b0); send(PB, 1'b0, 1'b0);
        drain("drain_s6_sof");
        chk("line_count_new_frame", {16'd0, line_count}, 32'd0);
        push(32'h88994455, 4'hF, 1'b0, 1'b0);
        push(32'hAABBCC77, 4'hF, 1'b1, 1'b0);
        send(PC, 1'b0, 1'b0); send(PD, 1'b0, 1'b1);
        drain("drain_s6_end");
        chk("line_count_after_line", {16'd0, line_count}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
